collision_scorer: RTL and testbench

COLLISION_SCORER -- requirements
Module: collision_scorer

---
 rtl/collision_scorer_if.sv | 32 +++
 rtl/collision_scorer.sv | 116 +++++++++++
 tb/tb_collision_scorer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/collision_scorer_if.sv
// Pixel stream, game control and verdict signals shared between the scorer and its driver.
interface collision_scorer_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic        is_wall_in;
  logic        is_person_in;
  logic [7:0]  wall_depth_in;
  logic        new_round_in;
  logic        start_in;
  logic        collision_pixel_out;
  logic [15:0] frame_collisions_out;
  logic        result_valid_out;
  logic        round_pass_out;
  logic [7:0]  score_out;
  logic [2:0]  lives_out;
  logic [1:0]  state_out;

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in,
           wall_depth_in, new_round_in, start_in,
    output collision_pixel_out, frame_collisions_out, result_valid_out,
           round_pass_out, score_out, lives_out, state_out
  );

  modport master (
    output hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in,
           wall_depth_in, new_round_in, start_in,
    input  collision_pixel_out, frame_collisions_out, result_valid_out,
           round_pass_out, score_out, lives_out, state_out
  );
endinterface

// File: rtl/collision_scorer.sv
// Counts wall/person overlap pixels per frame inside the depth window and scores rounds.
//
// state     | meaning
// IDLE      | waiting for start after reset
// PLAY      | counting collisions, waiting for end of wall travel
// RESULT    | one-cycle verdict strobe
// GAME_OVER | lives exhausted, final score held until start
module collision_scorer #(
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int GOAL_DEPTH       = 60,
  parameter int GOAL_DEPTH_DELTA = 10,
  parameter int PIXEL_THRESHOLD  = 256,
  parameter int MAX_LIVES        = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  collision_scorer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    RESULT    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int DEPTH_LO = GOAL_DEPTH - GOAL_DEPTH_DELTA;
  localparam int DEPTH_HI = GOAL_DEPTH + GOAL_DEPTH_DELTA;

  state_t      state, state_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic        hit_flag;
  int          depth_int;
  logic        window_active, collision, frame_end, frame_hit, round_hit;
  logic        game_start, judge, counting;

  assign depth_int     = int'(bus.wall_depth_in);
  assign window_active = (depth_int >= DEPTH_LO) && (depth_int <= DEPTH_HI);
  assign collision     = (state == PLAY) && bus.data_valid_in && bus.is_wall_in &&
                         bus.is_person_in && window_active;
  assign frame_end     = bus.data_valid_in &&
                         (bus.hcount_in == 11'(SCREEN_WIDTH - 1)) &&
                         (bus.vcount_in == 10'(SCREEN_HEIGHT - 1));
  assign frame_cnt_nxt = (collision && (frame_cnt != 16'hFFFF)) ? frame_cnt + 16'd1 : frame_cnt;
  assign frame_hit     = frame_cnt_nxt >= 16'(PIXEL_THRESHOLD);
  // A frame ending on the same cycle as new_round still counts toward this verdict.
  assign round_hit     = hit_flag || (frame_end && frame_hit);
  assign game_start    = bus.start_in && ((state == IDLE) || (state == GAME_OVER));
  assign judge         = (state == PLAY) && bus.new_round_in;
  assign counting      = (state == PLAY) || (state == RESULT);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.result_valid_out = 1'b0;
    case (state)
      IDLE:      if (bus.start_in) state_nxt = PLAY;
      PLAY:      if (bus.new_round_in) state_nxt = RESULT;
      RESULT: begin
        bus.result_valid_out = 1'b1;
        state_nxt = (bus.lives_out == 3'd0) ? GAME_OVER : PLAY;
      end
      GAME_OVER: if (bus.start_in) state_nxt = PLAY;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt                <= '0;
      hit_flag                 <= 1'b0;
      bus.collision_pixel_out  <= 1'b0;
      bus.frame_collisions_out <= '0;
      bus.round_pass_out       <= 1'b0;
      bus.score_out            <= '0;
      bus.lives_out            <= '0;
    end else begin
      bus.collision_pixel_out <= collision;
      if (game_start) begin
        frame_cnt                <= '0;
        hit_flag                 <= 1'b0;
        bus.frame_collisions_out <= '0;
        bus.score_out            <= '0;
        bus.lives_out            <= 3'(MAX_LIVES);
      end else begin
        // Partial frames keep counting through RESULT; only game start restarts them.
        if (counting) begin
          if (frame_end) begin
            bus.frame_collisions_out <= frame_cnt_nxt;
            frame_cnt                <= '0;
          end else begin
            frame_cnt <= frame_cnt_nxt;
          end
        end
        if (state == RESULT) hit_flag <= 1'b0;
        if (counting && frame_end && frame_hit) hit_flag <= 1'b1;
        if (judge) begin
          bus.round_pass_out <= !round_hit;
          if (!round_hit) begin
            if (bus.score_out != 8'hFF) bus.score_out <= bus.score_out + 8'd1;
          end else if (bus.lives_out != 3'd0) begin
            bus.lives_out <= bus.lives_out - 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_scorer.sv
// Directed checks of collision counting, verdicts, lives/score and reset for collision_scorer.
module tb_collision_scorer;
  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_fails  = 0;

  collision_scorer_if bus();

  collision_scorer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    bus.data_valid_in = 1'b0;
    bus.is_wall_in    = 1'b0;
    bus.is_person_in  = 1'b0;
    bus.new_round_in  = 1'b0;
    bus.start_in      = 1'b0;
  endtask

  // n ordinary (non frame-end) pixels of wall, optionally overlapping the person
  task automatic pix(input int n, input int depth, input logic overlap);
    bus.hcount_in     = 11'd0;
    bus.vcount_in     = 10'd0;
    bus.data_valid_in = 1'b1;
    bus.is_wall_in    = 1'b1;
    bus.is_person_in  = overlap;
    bus.wall_depth_in = 8'(depth);
    for (int i = 0; i < n; i++) step();
    idle_inputs();
  endtask

  task automatic frame_end_pix(input int depth, input logic overlap, input logic rnd);
    bus.hcount_in     = 11'd1279;
    bus.vcount_in     = 10'd719;
    bus.data_valid_in = 1'b1;
    bus.is_wall_in    = 1'b1;
    bus.is_person_in  = overlap;
    bus.wall_depth_in = 8'(depth);
    bus.new_round_in  = rnd;
    step();
    idle_inputs();
  endtask

  task automatic start_game();
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
  endtask

  // Ends the round, checks the RESULT cycle, then returns to the next state.
  task automatic do_round(input string tag, input logic pass, input int score, input int lives);
    bus.new_round_in = 1'b1;
    step();
    bus.new_round_in = 1'b0;
    check({tag, "_state"}, 32'(bus.state_out), 32'd2);
    check({tag, "_rv"},    32'(bus.result_valid_out), 32'd1);
    check({tag, "_pass"},  32'(bus.round_pass_out), 32'(pass));
    check({tag, "_score"}, 32'(bus.score_out), 32'(score));
    check({tag, "_lives"}, 32'(bus.lives_out), 32'(lives));
    step();
    check({tag, "_rv_off"}, 32'(bus.result_valid_out), 32'd0);
  endtask

  initial begin
    bus.wall_depth_in = 8'd60;
    idle_inputs();
    rst_in = 1'b1;
    step();
    step();
    check("rst_state", 32'(bus.state_out), 32'd0);
    check("rst_lives", 32'(bus.lives_out), 32'd0);
    check("rst_score", 32'(bus.score_out), 32'd0);
    check("rst_fc",    32'(bus.frame_collisions_out), 32'd0);
    check("rst_rv",    32'(bus.result_valid_out), 32'd0);
    rst_in = 1'b0;
    step();

    // new_round in IDLE is ignored
    bus.new_round_in = 1'b1;
    step();
    bus.new_round_in = 1'b0;
    check("idle_newround", 32'(bus.state_out), 32'd0);

    start_game();
    check("start_state", 32'(bus.state_out), 32'd1);
    check("start_lives", 32'(bus.lives_out), 32'd3);
    check("start_score", 32'(bus.score_out), 32'd0);

    // 300 overlaps at depth 60 -> hit round
    pix(1, 60, 1'b0);
    check("cp_zero", 32'(bus.collision_pixel_out), 32'd0);
    pix(1, 60, 1'b1);
    check("cp_one", 32'(bus.collision_pixel_out), 32'd1);
    pix(298, 60, 1'b1);
    frame_end_pix(60, 1'b1, 1'b0);
    check("fc_300", 32'(bus.frame_collisions_out), 32'd300);
    check("cp_fe", 32'(bus.collision_pixel_out), 32'd1);
    do_round("r300", 1'b0, 0, 2);
    check("r300_play", 32'(bus.state_out), 32'd1);

    // outside the window on both sides
    pix(299, 49, 1'b1);
    frame_end_pix(49, 1'b1, 1'b0);
    check("fc_d49", 32'(bus.frame_collisions_out), 32'd0);
    do_round("r49", 1'b1, 1, 2);
    pix(299, 71, 1'b1);
    frame_end_pix(71, 1'b1, 1'b0);
    check("fc_d71", 32'(bus.frame_collisions_out), 32'd0);
    do_round("r71", 1'b1, 2, 2);

    // window edges are inclusive
    pix(10, 50, 1'b1);
    frame_end_pix(50, 1'b0, 1'b0);
    check("fc_d50", 32'(bus.frame_collisions_out), 32'd10);
    pix(7, 70, 1'b1);
    frame_end_pix(70, 1'b0, 1'b0);
    check("fc_d70", 32'(bus.frame_collisions_out), 32'd7);
    do_round("redge", 1'b1, 3, 2);

    // threshold boundary
    pix(255, 60, 1'b1);
    frame_end_pix(60, 1'b0, 1'b0);
    check("fc_255", 32'(bus.frame_collisions_out), 32'd255);
    do_round("r255", 1'b1, 4, 2);
    pix(256, 60, 1'b1);
    frame_end_pix(60, 1'b0, 1'b0);
    check("fc_256", 32'(bus.frame_collisions_out), 32'd256);
    do_round("r256", 1'b0, 4, 1);

    // frame-end pixel is the 256th overlap, same cycle as new_round -> last life lost
    pix(255, 60, 1'b1);
    frame_end_pix(60, 1'b1, 1'b1);
    check("same_state", 32'(bus.state_out), 32'd2);
    check("same_rv",    32'(bus.result_valid_out), 32'd1);
    check("same_pass",  32'(bus.round_pass_out), 32'd0);
    check("same_lives", 32'(bus.lives_out), 32'd0);
    check("same_fc",    32'(bus.frame_collisions_out), 32'd256);
    step();
    check("go_state", 32'(bus.state_out), 32'd3);
    check("go_score", 32'(bus.score_out), 32'd4);
    bus.new_round_in = 1'b1;
    step();
    bus.new_round_in = 1'b0;
    check("go_newround", 32'(bus.state_out), 32'd3);
    check("go_rv", 32'(bus.result_valid_out), 32'd0);
    start_game();
    check("restart_state", 32'(bus.state_out), 32'd1);
    check("restart_lives", 32'(bus.lives_out), 32'd3);
    check("restart_score", 32'(bus.score_out), 32'd0);
    check("restart_fc",    32'(bus.frame_collisions_out), 32'd0);

    // start in PLAY ignored; partial frame continues across RESULT
    pix(100, 60, 1'b1);
    start_game();
    check("play_start_state", 32'(bus.state_out), 32'd1);
    do_round("rpart", 1'b1, 1, 3);
    pix(200, 60, 1'b1);
    frame_end_pix(60, 1'b0, 1'b0);
    check("fc_across", 32'(bus.frame_collisions_out), 32'd300);
    do_round("racross", 1'b0, 1, 2);

    // score saturation
    for (int i = 0; i < 260; i++) begin
      bus.new_round_in = 1'b1;
      step();
      bus.new_round_in = 1'b0;
      step();
    end
    check("score_sat", 32'(bus.score_out), 32'd255);
    check("score_sat_lives", 32'(bus.lives_out), 32'd2);

    // frame counter saturation
    pix(65540, 60, 1'b1);
    frame_end_pix(60, 1'b1, 1'b0);
    check("fc_sat", 32'(bus.frame_collisions_out), 32'hFFFF);
    do_round("rsat", 1'b0, 255, 1);

    // reset mid-frame in PLAY
    pix(5, 60, 1'b1);
    rst_in = 1'b1;
    bus.data_valid_in = 1'b1;
    bus.is_wall_in    = 1'b1;
    bus.is_person_in  = 1'b1;
    step();
    idle_inputs();
    check("rstp_state", 32'(bus.state_out), 32'd0);
    check("rstp_cp",    32'(bus.collision_pixel_out), 32'd0);
    check("rstp_fc",    32'(bus.frame_collisions_out), 32'd0);
    check("rstp_score", 32'(bus.score_out), 32'd0);
    check("rstp_lives", 32'(bus.lives_out), 32'd0);
    rst_in = 1'b0;
    step();

    // reset during RESULT after a passing verdict
    start_game();
    bus.new_round_in = 1'b1;
    step();
    bus.new_round_in = 1'b0;
    check("pre_rst_pass", 32'(bus.round_pass_out), 32'd1);
    rst_in = 1'b1;
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
    check("rstr_state", 32'(bus.state_out), 32'd0);
    check("rstr_rv",    32'(bus.result_valid_out), 32'd0);
    check("rstr_pass",  32'(bus.round_pass_out), 32'd0);
    check("rstr_score", 32'(bus.score_out), 32'd0);
    rst_in = 1'b0;
    step();
    check("rstr_rv_after", 32'(bus.result_valid_out), 32'd0);
    check("rstr_state_after", 32'(bus.state_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
